// File: rtl/instr_sequencer_if.sv
// Program-load and control_unit handshake bundle for instr_sequencer.
// master = sequencer side (drives run/instruction), slave = loader and control_unit side.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              cu_done;
  logic              run;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              finished;
  logic              err;

  modport master (
    input  wr_en, wr_addr, wr_data, prog_len, start, cu_done,
    output run, instruction, pc, busy, finished, err
  );

  modport slave (
    output wr_en, wr_addr, wr_data, prog_len, start, cu_done,
    input  run, instruction, pc, busy, finished, err
  );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a small instruction memory to control_unit over run/instruction/done, one GAP cycle between issues.
// Optional WATCHDOG_EN macro adds an ISSUE-stall timeout that aborts the program and raises err.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);
  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("instr_sequencer: TIMEOUT must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [15:0]       instr_q, instr_d;
  logic              run_q, busy_q, fin_q;
  logic [15:0]       mem_q [DEPTH];

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    instr_d = instr_q;
`ifdef WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef WATCHDOG_EN
          err_d = 1'b0;
`endif
          if (bus.prog_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_GAP;
            pc_d    = '0;
            // prog_len = DEPTH has zero low bits, so this wraps to DEPTH-1 as wanted
            last_d  = bus.prog_len[ADDR_W-1:0] - ADDR_W'(1);
          end
        end
      end
      S_GAP: begin
        state_d = S_ISSUE;
        instr_d = mem_q[pc_q];
`ifdef WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_ISSUE: begin
        if (bus.cu_done) begin
          if (pc_q == last_q) begin
            state_d = S_FIN;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_GAP;
          end
        end
`ifdef WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      instr_q <= 16'h0000;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      instr_q <= instr_d;
      run_q   <= (state_d == S_ISSUE);
      busy_q  <= (state_d != S_IDLE);
      fin_q   <= (state_d == S_FIN);
`ifdef WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Program memory survives reset
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.run         = run_q;
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = fin_q;
`ifdef WATCHDOG_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: per-run issue schedule computed arithmetically from done latencies.
module tb_instr_sequencer;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge with the block idle; returns at a negedge.
  task automatic write_mem(input int a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[ADDR_W-1:0];
    bus.wr_data = d;
    model_mem[a] = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // mode 0: done in 4th run cycle; 1: random latency 1..6; 2: done never comes (n must be 1)
  task automatic run_prog(input int n, input int mode, input bit noise);
    int st[DEPTH];
    int en[DEPTH];
    int fin, t, lat, k_act;
    bit abort, exp_run;
    abort = 1'b0;
    t = 2;
    for (int k = 0; k < n; k++) begin
      if (mode == 0) lat = 4;
      else if (mode == 1) lat = $urandom_range(1, 6);
      else begin
`ifdef WATCHDOG_EN
        lat = TIMEOUT;
        abort = 1'b1;
`else
        lat = 120;
`endif
      end
      st[k] = t;
      en[k] = t + lat - 1;
      t = en[k] + 2;
    end
    fin = (n == 0) ? 1 : en[n-1] + 1;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = (ADDR_W+1)'(n);
    bus.cu_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;

    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      exp_run = 1'b0;
      k_act   = 0;
      for (int k = 0; k < n; k++) begin
        if (c >= st[k] && c <= en[k]) begin
          exp_run = 1'b1;
          k_act   = k;
        end
      end
      check("run", bus.run, exp_run);
      check("busy", bus.busy, c <= fin);
      check("finished", bus.finished, c == fin);
      check("err", bus.err, abort && c >= fin);
      if (exp_run) begin
        check("instruction", bus.instruction, model_mem[k_act]);
        check("pc", bus.pc, k_act);
      end
      if (abort && c >= fin) check("pc_stalled", bus.pc, 0);

      bus.start    = (noise && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.prog_len = (ADDR_W+1)'($urandom_range(0, DEPTH));
      if (exp_run) bus.cu_done = (c == en[k_act]) && !abort;
      else         bus.cu_done = (noise && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wr_en    = (noise && c <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.wr_data  = 16'($urandom);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.prog_len = '0;
    bus.start    = 1'b0;
    bus.cu_done  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;

    repeat (2) @(negedge clk);
    check("rst_run", bus.run, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_finished", bus.finished, 0);
    check("rst_err", bus.err, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_instruction", bus.instruction, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    write_mem(0, 16'hA001);
    write_mem(1, 16'h2405);
    write_mem(2, 16'h4C21);
    run_prog(3, 0, 0);
    run_prog(0, 0, 1);

    // writes and starts while busy are dropped; a write once idle lands
    run_prog(3, 1, 1);
    write_mem(1, 16'hFFFF);
    run_prog(3, 0, 0);

    // asynchronous reset in the middle of the first ISSUE
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_run", bus.run, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_run", bus.run, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_pc", bus.pc, 0);
    check("async_rst_finished", bus.finished, 0);
    check("async_rst_instruction", bus.instruction, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(3, 1, 0);

    for (int i = 0; i < DEPTH; i++) write_mem(i, 16'($urandom));
    run_prog(16, 0, 0);
    run_prog(16, 1, 1);

    run_prog(1, 2, 0);
    run_prog(2, 1, 0);

    repeat (4) begin
      for (int i = 0; i < 4; i++) write_mem($urandom_range(0, DEPTH - 1), 16'($urandom));
      run_prog($urandom_range(0, DEPTH), 1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program-driving front end for `control_unit`: holds a small instruction memory and issues each instruction over the `run`/`instruction`/`done` interface. For each instruction it raises `run` with a fresh 0→1 edge, holds `run` and the instruction stable until `done`, then advances. It sits between the program loader (test harness or host) and `control_unit`, replacing manual toggling of `run`.

## Interface
- `ADDR_W`, default 4: instruction memory address width; memory depth = 2**ADDR_W words of 16 bits.
- `TIMEOUT`, default 15: watchdog limit in cycles; used only when `WATCHDOG_EN` is defined.

Ports:
- `clk` input, 1: sole clock, rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `wr_en` input, 1: program memory write strobe; ignored while `busy`=1.
- `wr_addr` input, ADDR_W: write address.
- `wr_data` input, 16: instruction word to write.
- `prog_len` input, ADDR_W+1: number of instructions to run, 0..2**ADDR_W; sampled with `start`.
- `start` input, 1: begin the program at address 0; sampled only in IDLE.
- `cu_done` input, 1: the `done` output of `control_unit`.
- `run` output, 1: drives `control_unit.run`.
- `instruction` output, 16: drives `control_unit.instruction`.
- `pc` output, ADDR_W: address of the instruction currently issued.
- `busy` output, 1: high in any state except IDLE.
- `finished` output, 1: one-cycle pulse when the program ends.
- `err` output, 1: watchdog abort flag. It is sticky until the next accepted `start`.

## Operation
- States:
  - IDLE (`run`=0). Accepted `start` with `prog_len`=0 → FIN. Accepted `start` with `prog_len`>0 → GAP, with `pc`=0, `last`=`prog_len`-1 latched, and `err` cleared.
  - GAP (`run`=0). Lasts exactly 1 cycle, then → ISSUE. On the leaving edge, `instruction` ← mem[`pc`] and `run` ← 1.
  - ISSUE (`run`=1, `instruction` held). If `cu_done`=1 and `pc`==`last`, → FIN. If `cu_done`=1 otherwise, `pc`++ and → GAP. If `cu_done`=0, stay.
  - FIN (`run`=0, `finished`=1). Lasts 1 cycle, then → IDLE.
- The GAP cycle guarantees that `control_unit` sees `run` low for at least one sampled edge. Its `run_prev` register is then 0 when `run` rises, so its INITIAL→LOAD edge detect fires.
- `cu_done` outside ISSUE is ignored. `start` while `busy` is ignored.
- Memory writes are synchronous and take effect only when `busy`=0. Memory is not cleared by reset.
- `pc` never wraps: with `prog_len`=2**ADDR_W, the last instruction is at `pc`=2**ADDR_W-1 and the block goes to FIN.

## Timing
- Reset values: state=IDLE, `run`=0, `instruction`=16'h0000, `pc`=0, `busy`=0, `finished`=0, `err`=0.
- All outputs are registered. Asserting `reset` at any point, including mid-ISSUE, forces `run`=0 immediately and returns all outputs to their reset values.
- Cycle numbering: `start` is high in cycle 0 and sampled at edge 1.
  - Cycle 1 is GAP.
  - Instruction k (0-based) holds `run`=1 during cycles 5k+2 .. 5k+5 when `control_unit` returns `done` in its 4th run cycle.
  - `finished`=1 in cycle 5N+1; IDLE resumes in cycle 5N+2.
- Throughput: 5 cycles per instruction against `control_unit`. A longer `done` latency stretches ISSUE accordingly.

## Configuration
- `WATCHDOG_EN` defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle with `cu_done`=0.
  - On reaching `TIMEOUT`, the block drops `run`, goes to FIN, and sets `err`=1. `pc` holds the stalled address.
- `WATCHDOG_EN` undefined:
  - No counter exists; ISSUE waits indefinitely.
  - `err` is tied to 0.

## Test plan
- Load 16'hA001, 16'h2405, 16'h4C21 at addresses 0-2, `prog_len`=3, bench model returns done in its 4th run cycle → `run` high in cycles 2-5, 7-10 and 12-15 with those instructions in order, `pc` 0/1/2, and `finished` in cycle 16.
- `start` with `prog_len`=0 → `finished` in cycle 1, `run` never high, `busy` high for 1 cycle only.
- While busy, pulse `wr_en` to address 1 with 16'hFFFF and pulse `start` again → program runs unaltered and the second `start` is ignored. After FIN, the write takes effect.
- Assert `reset` in cycle 4 (mid-ISSUE) → `run`=0, `busy`=0, `pc`=0 without waiting for a clock edge. After release, a new `start` runs from address 0.
- Run with `prog_len`=16 and all locations loaded → 16 issues with `pc` 0..15, no wrap, and `finished` in cycle 81.
- Hold `cu_done` at 0:
  - With `WATCHDOG_EN`: `run` falls after 15 ISSUE cycles, `err`=1 and `finished` pulses.
  - Without `WATCHDOG_EN`: `run` stays high for at least 100 cycles and `err`=0.
